// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU function codes and arbiter FSM states.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_MULT  = 4'h2,
        OP_DIV   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_NAND  = 4'h6,
        OP_NOR   = 4'h7,
        OP_XOR   = 4'h8,
        OP_XNOR  = 4'h9,
        OP_CMPEQ = 4'hA,
        OP_CMPGT = 4'hB,
        OP_CMPLT = 4'hC,
        OP_SHR   = 4'hD,
        OP_SHL   = 4'hE,
        OP_NOP   = 4'hF
    } alu_op_t;

    localparam logic [3:0] ALU_NOP = OP_NOP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Rotating-priority picker: the first valid requester after the last grant wins.
module rr_grant #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [31:0]      w_pos;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = '0;
        w_sel       = '0;
        // Offsets 1..NUM_REQ visit every index once, ending on last_grant itself.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_pos = (32'(i_last_grant) + off) % NUM_REQ;
            w_sel = IDX_W'(w_pos);
            if (!o_any && i_req_valid[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters; one command in flight,
// round-robin grant, one-cycle ALU enable and one-cycle response pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 4,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]    req_fun,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [DATA_WIDTH-1:0]               alu_a,
    output logic [DATA_WIDTH-1:0]               alu_b,
    output logic [OP_WIDTH-1:0]                 alu_fun,
    output logic                                alu_en,
    input  logic [2*DATA_WIDTH-1:0]             alu_out,
    input  logic                                alu_out_valid,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [2*DATA_WIDTH-1:0]             rsp_data,
    output logic                                rsp_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t              r_state;
    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        r_gnt_idx;
    logic [NUM_REQ-1:0]      r_gnt_oh;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [OP_WIDTH-1:0]     r_fun;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;
    logic                    r_rsp_err;

    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_any;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gnt_idx),
        .o_any        (w_any)
    );

    // Accept is combinational from IDLE; gated by RST so it stays low while reset is held.
    assign req_ready = (r_state == ST_IDLE && RST) ? w_grant : '0;
    assign alu_en    = (r_state == ST_ISSUE);
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_fun   = r_fun;
    assign rsp_valid = (r_state == ST_RESP) ? r_gnt_oh : '0;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_gnt_idx  <= '0;
            r_gnt_oh   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_fun      <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a       <= req_a[w_gnt_idx];
                        r_b       <= req_b[w_gnt_idx];
                        r_fun     <= req_fun[w_gnt_idx];
                        r_gnt_idx <= w_gnt_idx;
                        r_gnt_oh  <= w_grant;
                        if (req_fun[w_gnt_idx] == OP_WIDTH'(ALU_NOP)) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b0;
                            r_state    <= ST_RESP;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving in the final allowed cycle still beats the timeout.
                    if (alu_out_valid) begin
                        r_rsp_data <= alu_out;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_last  <= r_gnt_idx;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
